// File: rtl/gabor_out_writer.sv
// gabor_out_writer: buffers signed Gabor results, clamps them to pixels and writes them to the output BRAMs in raster order.
// Optional feature macro GABOR_WR_SAT_EN: saturate oversized magnitudes to full scale and raise sat_flag.
module gabor_out_writer #(
    parameter int OUT_WIDTH  = 508,
    parameter int OUT_HEIGHT = 508,
    parameter int RES_W      = 20,
    parameter int PIX_W      = 8,
    parameter int ADDR_W     = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RES_W-1:0]  in_res45,
    input  logic [RES_W-1:0]  in_res90,
    input  logic [RES_W-1:0]  in_res135,
    input  logic [RES_W-1:0]  in_res180,
    input  logic              bram_grant,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [PIX_W-1:0]  bram_din45,
    output logic [PIX_W-1:0]  bram_din90,
    output logic [PIX_W-1:0]  bram_din135,
    output logic [PIX_W-1:0]  bram_din180,
    output logic              busy,
    output logic              frame_done,
    output logic              sat_flag
);
    localparam int TOTAL = OUT_WIDTH * OUT_HEIGHT;
    localparam int CW = $clog2(TOTAL + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [RES_W-2:0] MAXV = (RES_W-1)'((1 << PIX_W) - 1);
`ifdef GABOR_WR_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]             cnt_q, cnt_d;
    logic [CW-1:0]           acc_q, acc_d, wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [3:0][PIX_W-1:0]   din_q, din_d, pix;
    logic                    we_q, we_d, busy_q, busy_d, done_q, done_d, sat_q, sat_d;
    logic [3:0][RES_W-1:0]   mem_q [FIFO_DEPTH];
    logic [3:0][RES_W-1:0]   head;
    logic [3:0]              sat_ch;
    logic                    push, pop;

    // A full FIFO still accepts when the head leaves in the same cycle
    assign pop      = (state_q == RUN) && (cnt_q != '0) && bram_grant;
    assign in_ready = (state_q == RUN) && ((cnt_q != (PW+1)'(FIFO_DEPTH)) || pop) && (acc_q < CW'(TOTAL));
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rp_q];

    // Per-channel clamp of the FIFO head: negative to zero, optional saturation above full scale
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sat_ch[i] = SAT_EN && !head[i][RES_W-1] && (head[i][RES_W-2:0] > MAXV);
            pix[i]    = head[i][RES_W-1] ? '0 : sat_ch[i] ? '1 : head[i][PIX_W-1:0];
        end
    end

    // Next-state logic for the FIFO pointers, counters, FSM and registered outputs
    always_comb begin
        state_d = state_q;
        wp_d    = push ? wp_q + 1'b1 : wp_q;
        rp_d    = pop ? rp_q + 1'b1 : rp_q;
        cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        acc_d   = push ? acc_q + 1'b1 : acc_q;
        wcnt_d  = pop ? wcnt_q + 1'b1 : wcnt_q;
        addr_d  = pop ? ADDR_W'(wcnt_q) : addr_q;
        din_d   = pop ? pix : din_q;
        we_d    = pop;
        done_d  = 1'b0;
        busy_d  = busy_q;
        sat_d   = sat_q | (pop && (|sat_ch));
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                busy_d  = 1'b1;
                sat_d   = 1'b0;
                acc_d   = '0;
                wcnt_d  = '0;
                addr_d  = '0;
            end
            RUN: if (wcnt_q == CW'(TOTAL)) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                acc_d   = '0;
                wcnt_d  = '0;
                addr_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= {in_res180, in_res135, in_res90, in_res45};
    end

    assign bram_we     = we_q;
    assign bram_addr   = addr_q;
    assign bram_din45  = din_q[0];
    assign bram_din90  = din_q[1];
    assign bram_din135 = din_q[2];
    assign bram_din180 = din_q[3];
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign sat_flag    = sat_q;
endmodule

// File: tb/tb_gabor_out_writer.sv
// tb_gabor_out_writer: directed self-checking bench for gabor_out_writer on a 4x4 frame.
module tb_gabor_out_writer;
    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, bram_grant;
    logic [19:0] in_res45, in_res90, in_res135, in_res180;
    logic        in_ready, bram_we, busy, frame_done, sat_flag;
    logic [17:0] bram_addr;
    logic [7:0]  bram_din45, bram_din90, bram_din135, bram_din180;

    int n_chk = 0, n_fail = 0, acc_n = 0, cyc = 0, fd_n = 0, fd_cyc = 0, last_w_cyc = 0;
    logic [17:0] qa[$];
    logic [31:0] qd[$];

`ifdef GABOR_WR_SAT_EN
    localparam logic [7:0] E300 = 8'd255;
    localparam logic       ESAT = 1'b1;
`else
    localparam logic [7:0] E300 = 8'd44;
    localparam logic       ESAT = 1'b0;
`endif

    gabor_out_writer #(.OUT_WIDTH(4), .OUT_HEIGHT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_res45(in_res45), .in_res90(in_res90), .in_res135(in_res135), .in_res180(in_res180),
        .bram_grant(bram_grant), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din45(bram_din45), .bram_din90(bram_din90), .bram_din135(bram_din135), .bram_din180(bram_din180),
        .busy(busy), .frame_done(frame_done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        #1;
        if (in_valid && in_ready) acc_n++;
        @(posedge clk);
        #1;
        cyc++;
        if (bram_we) begin
            qa.push_back(bram_addr);
            qd.push_back({bram_din180, bram_din135, bram_din90, bram_din45});
            last_w_cyc = cyc;
        end
        if (frame_done) begin
            fd_n++;
            fd_cyc = cyc;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        bram_grant = 1'b0;
        in_res45 = '0; in_res90 = '0; in_res135 = '0; in_res180 = '0;
        step();
        step();
        rst_n = 1'b1;
        qa.delete();
        qd.delete();
        acc_n = 0;
        fd_n = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [19:0] a, input logic [19:0] b, input logic [19:0] c, input logic [19:0] d);
        int n0;
        n0 = acc_n;
        in_res45 = a; in_res90 = b; in_res135 = c; in_res180 = d;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && acc_n == n0; k++) step();
        in_valid = 1'b0;
        chk("send_hs", acc_n - n0, 1);
    endtask

    task automatic wait_writes(input int n);
        for (int k = 0; k < 50 && qa.size() < n; k++) step();
        chk("wr_count", qa.size(), n);
    endtask

    initial begin
        int n, bad;
        // Reset state, with start held to confirm reset priority
        do_reset();
        rst_n = 1'b0;
        start = 1'b1;
        step();
        step();
        chk("rst_ready", in_ready, 0);
        chk("rst_we", bram_we, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_din", {bram_din180, bram_din135, bram_din90, bram_din45}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_sat", sat_flag, 0);
        start = 1'b0;
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // Basic clamping
        pulse_start();
        chk("run_busy", busy, 1);
        bram_grant = 1'b1;
        in_res45 = 20'd100; in_res90 = 20'h80007; in_res135 = 20'd0; in_res180 = 20'd255;
        in_valid = 1'b1;
        #1;
        chk("clamp_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        step();
        chk("clamp_we", bram_we, 1);
        chk("clamp_addr", bram_addr, 0);
        chk("clamp_d45", bram_din45, 100);
        chk("clamp_d90", bram_din90, 0);
        chk("clamp_d135", bram_din135, 0);
        chk("clamp_d180", bram_din180, 255);
        step();
        chk("idle_we", bram_we, 0);
        chk("hold_d180", bram_din180, 255);

        // Saturation and stickiness
        send(20'd300, 20'd0, 20'd0, 20'd0);
        wait_writes(2);
        chk("sat_d45", bram_din45, E300);
        chk("sat_flag", sat_flag, ESAT);
        chk("sat_addr", bram_addr, 1);
        send(20'd5, 20'd0, 20'd0, 20'd0);
        wait_writes(3);
        chk("sticky_d45", bram_din45, 5);
        chk("sticky_flag", sat_flag, ESAT);
        chk("sticky_addr", bram_addr, 2);

        // Backpressure, full-FIFO push+pop and start during RUN
        do_reset();
        pulse_start();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_res45 = 20'(acc_n + 1);
            step();
        end
        in_res45 = 20'(acc_n + 1);
        chk("bp_accepted", acc_n, 4);
        chk("bp_ready_full", in_ready, 0);
        chk("bp_no_write", qa.size(), 0);
        bram_grant = 1'b1;
        #1;
        chk("bp_ready_pushpop", in_ready, 1);
        for (int k = 0; k < 20 && qa.size() < 5; k++) begin
            in_valid = (acc_n < 5);
            start = (k == 2);
            step();
        end
        start = 1'b0;
        in_valid = 1'b0;
        chk("bp_writes", qa.size(), 5);
        bad = 0;
        for (int i = 0; i < qa.size(); i++)
            if (qa[i] != 18'(i) || qd[i][7:0] != 8'(i + 1)) bad++;
        chk("bp_order", bad, 0);

        // Full 4x4 frame
        do_reset();
        pulse_start();
        bram_grant = 1'b1;
        for (int k = 0; k < 100 && acc_n < 16; k++) begin
            in_valid = 1'b1;
            in_res45 = 20'(acc_n);
            step();
        end
        in_valid = 1'b1;
        #1;
        chk("frame_ready_cap", in_ready, 0);
        for (int k = 0; k < 30 && fd_n == 0; k++) step();
        in_valid = 1'b0;
        chk("frame_writes", qa.size(), 16);
        bad = 0;
        for (int i = 0; i < qa.size(); i++)
            if (qa[i] != 18'(i) || qd[i][7:0] != 8'(i)) bad++;
        chk("frame_order", bad, 0);
        chk("frame_done_n", fd_n, 1);
        chk("frame_done_lat", fd_cyc - last_w_cyc, 1);
        chk("done_busy", busy, 1);
        step();
        chk("done_pulse", frame_done, 0);
        chk("post_busy", busy, 0);
        chk("post_addr", bram_addr, 0);

        // Reset mid-frame
        do_reset();
        pulse_start();
        bram_grant = 1'b1;
        send(20'd300, 20'd0, 20'd0, 20'd0);
        send(20'd2, 20'd0, 20'd0, 20'd0);
        send(20'd3, 20'd0, 20'd0, 20'd0);
        wait_writes(3);
        n = qa.size();
        in_valid = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        step();
        chk("mrst_nowr", qa.size(), n);
        chk("mrst_addr", bram_addr, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", in_ready, 0);
        chk("mrst_sat", sat_flag, 0);
        chk("mrst_din", {bram_din180, bram_din135, bram_din90, bram_din45}, 0);
        rst_n = 1'b1;
        step();
        step();
        chk("mrst_needs_start", qa.size(), n);
        in_valid = 1'b0;
        pulse_start();
        send(20'd7, 20'd0, 20'd0, 20'd0);
        wait_writes(n + 1);
        chk("mrst_addr0", bram_addr, 0);
        chk("mrst_d45", bram_din45, 7);
        chk("mrst_sat_clr", sat_flag, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
